// File: rtl/ex_div.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Holds the EX stall request while iterating and releases it in the result cycle.
module ex_div #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  cancel_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  stallreq_o
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [W-1:0]     MIN_NEG  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     rem_q;
  logic [W-1:0]     quo_q;
  logic [W-1:0]     dvs_q;
  logic             op_rem_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  logic             signed_op;
  logic             neg_a;
  logic             neg_b;
  logic [W-1:0]     abs_a;
  logic [W-1:0]     abs_b;
  logic             div_zero;
  logic             ovf;
  logic [W-1:0]     special_res;

  logic [W:0]       shifted;
  logic [W:0]       diff;
  logic             q_bit;
  logic [W-1:0]     rem_nxt;
  logic [W-1:0]     quo_nxt;
  logic [W-1:0]     final_res;

  assign stallreq_o = start_i & ~ready_o & ~cancel_i;

  // Operand magnitudes, sign flags and the results that bypass iteration.
  always_comb begin
    signed_op   = ~op_i[0];
    neg_a       = signed_op & dividend_i[W-1];
    neg_b       = signed_op & divisor_i[W-1];
    abs_a       = neg_a ? -dividend_i : dividend_i;
    abs_b       = neg_b ? -divisor_i : divisor_i;
    div_zero    = (divisor_i == '0);
    ovf         = signed_op & (dividend_i == MIN_NEG) & (divisor_i == '1);
    special_res = '0;
    if (div_zero) begin
      special_res = op_i[1] ? dividend_i : '1;
    end else begin
      special_res = op_i[1] ? '0 : MIN_NEG;
    end
  end

  // One restoring step; the quotient bits shift into the vacated dividend register.
  always_comb begin
    shifted   = {rem_q, quo_q[W-1]};
    diff      = shifted - {1'b0, dvs_q};
    q_bit     = ~diff[W];
    rem_nxt   = q_bit ? diff[W-1:0] : shifted[W-1:0];
    quo_nxt   = {quo_q[W-2:0], q_bit};
    final_res = '0;
    if (op_rem_q) begin
      final_res = neg_rem_q ? -rem_nxt : rem_nxt;
    end else begin
      final_res = neg_quo_q ? -quo_nxt : quo_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      op_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_o  <= '0;
      ready_o   <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !cancel_i) begin
            op_rem_q  <= op_i[1];
            neg_quo_q <= neg_a ^ neg_b;
            neg_rem_q <= neg_a;
            quo_q     <= abs_a;
            dvs_q     <= abs_b;
            rem_q     <= '0;
            cnt       <= '0;
            busy_o    <= 1'b1;
            if (div_zero || ovf) begin
              result_o <= special_res;
              ready_o  <= 1'b1;
              state    <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          // A flush or the instruction leaving EX abandons the operation.
          if (cancel_i || !start_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt   <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
              result_o <= final_res;
              ready_o  <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: table of directed divides plus
// cancel, back-to-back, flush-in-DONE and mid-operation reset sequences.
module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        cancel_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic        busy_o;
  logic        stallreq_o;

  int unsigned n_vec;
  int unsigned n_err;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int unsigned lat;
  } vec_t;

  ex_div #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .cancel_i   (cancel_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .stallreq_o (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits for ready_o, counting stall-request cycles; optionally scrambles
  // the operand inputs after acceptance to show they are ignored.
  task automatic wait_result(input bit scramble, output int unsigned stalls, output bit got);
    stalls = 0;
    got    = 1'b0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (ready_o) begin
        got = 1'b1;
        break;
      end
      if (stallreq_o) stalls++;
      @(negedge clk);
      if (scramble) begin
        op_i       = 2'($urandom);
        dividend_i = $urandom;
        divisor_i  = $urandom;
      end
    end
  endtask

  task automatic run_div(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input int unsigned lat);
    int unsigned stalls;
    bit          got;
    @(negedge clk);
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    wait_result(1'b1, stalls, got);
    check({name, " ready seen"}, 32'(got), 32'd1);
    check({name, " stall cycles"}, stalls, lat);
    check({name, " result"}, result_o, res);
    check({name, " busy/stallreq in DONE"}, 32'({busy_o, stallreq_o}), 32'b10);
    start_i = 1'b0;
    @(negedge clk);
    #1;
    check({name, " ready/busy after DONE"}, 32'({ready_o, busy_o}), 32'b00);
  endtask

  vec_t vecs[15];

  initial begin
    int unsigned stalls;
    bit          got;

    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[4]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
    vecs[5]  = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[6]  = '{OP_REM,  32'h0000_1234,  32'd0,          32'h0000_1234,  1};
    vecs[7]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[8]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  1};
    vecs[9]  = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
    vecs[10] = '{OP_REMU, 32'hFFFF_FFFF,  32'h10,         32'h0000_000F,  33};
    vecs[11] = '{OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  33};
    vecs[12] = '{OP_REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  33};
    vecs[13] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  33};
    vecs[14] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33};

    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b0;
    start_i    = 1'b0;
    cancel_i   = 1'b0;
    op_i       = 2'b00;
    dividend_i = '0;
    divisor_i  = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset result", result_o, 32'h0);
    check("reset ready/busy/stallreq", 32'({ready_o, busy_o, stallreq_o}), 32'b000);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
    end

    // Flush at CALC cycle 10, then a fresh divide.
    @(negedge clk);
    op_i       = OP_DIVU;
    dividend_i = 32'd1000;
    divisor_i  = 32'd3;
    start_i    = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("cancel: busy before flush", 32'(busy_o), 32'd1);
    cancel_i = 1'b1;
    #1;
    check("cancel: stallreq during flush", 32'(stallreq_o), 32'd0);
    @(negedge clk);
    #1;
    check("cancel: ready/busy after flush", 32'({ready_o, busy_o}), 32'b00);
    cancel_i = 1'b0;
    start_i  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("cancel: no late ready", 32'(ready_o), 32'd0);
    end
    run_div("after cancel", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

    // Back-to-back with start_i held through the DONE cycle.
    @(negedge clk);
    op_i       = OP_DIVU;
    dividend_i = 32'd50;
    divisor_i  = 32'd5;
    start_i    = 1'b1;
    wait_result(1'b0, stalls, got);
    check("b2b first ready seen", 32'(got), 32'd1);
    check("b2b first stall cycles", stalls, 32'd33);
    check("b2b first result", result_o, 32'd10);
    op_i       = OP_REMU;
    dividend_i = 32'd50;
    divisor_i  = 32'd8;
    @(negedge clk);
    #1;
    check("b2b idle gap ready/busy/stallreq", 32'({ready_o, busy_o, stallreq_o}), 32'b001);
    wait_result(1'b0, stalls, got);
    check("b2b second ready seen", 32'(got), 32'd1);
    check("b2b second stall cycles", stalls, 32'd33);
    check("b2b second result", result_o, 32'd2);
    start_i = 1'b0;
    @(negedge clk);
    #1;
    check("b2b ready/busy after", 32'({ready_o, busy_o}), 32'b00);

    // Flush arriving in the DONE cycle.
    @(negedge clk);
    op_i       = OP_DIVU;
    dividend_i = 32'd5;
    divisor_i  = 32'd0;
    start_i    = 1'b1;
    @(negedge clk);
    #1;
    check("done-flush ready", 32'(ready_o), 32'd1);
    cancel_i = 1'b1;
    #1;
    check("done-flush stallreq", 32'(stallreq_o), 32'd0);
    @(negedge clk);
    start_i  = 1'b0;
    cancel_i = 1'b0;
    #1;
    check("done-flush ready/busy after", 32'({ready_o, busy_o}), 32'b00);

    // Reset in the middle of an iteration.
    @(negedge clk);
    op_i       = OP_DIVU;
    dividend_i = 32'd100;
    divisor_i  = 32'd7;
    start_i    = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("mid reset result", result_o, 32'h0);
    check("mid reset ready/busy/stallreq", 32'({ready_o, busy_o, stallreq_o}), 32'b001);
    rst     = 1'b1;
    start_i = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
